// File: rtl/exe_stage_unit_pkg.sv
// ---------------------------------------------------------------------------
// exe_stage_unit_pkg
//   Shared constants and types for the execute stage: datapath widths, ALU
//   command encodings, shifter type codes, the NZCV flag struct and a word
//   rotate helper used by the Val2 generator.
// ---------------------------------------------------------------------------
package exe_stage_unit_pkg;

  localparam int ADDRESS_LEN  = 32;
  localparam int REGISTER_LEN = 32;
  localparam int EXEC_CMD_LEN = 4;
  localparam int SHIFT_OP_LEN = 12;
  localparam int SHAMT_LEN    = $clog2(REGISTER_LEN);

  typedef enum logic [EXEC_CMD_LEN-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exec_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Rotate right: the doubled word shifted right leaves the wrapped bits in
  // the low half.
  function automatic logic [REGISTER_LEN-1:0] ror_word(
    input logic [REGISTER_LEN-1:0] x,
    input logic [SHAMT_LEN-1:0]    amt
  );
    logic [2*REGISTER_LEN-1:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[REGISTER_LEN-1:0];
  endfunction

endpackage

// File: rtl/exe_stage_unit_val2_generator.sv
// ---------------------------------------------------------------------------
// val2_generator
//   Purely combinational second-operand generator.
//   Ports:
//     mem_op        in   load/store: Val2 is the zero-extended 12-bit offset
//     immediate     in   I bit: Val2 is imm8 rotated right by 2*rotate_imm
//     val_rm        in   register operand for the shifter path
//     shift_operand in   12-bit shifter operand field
//     val2          out  resulting second ALU operand
// ---------------------------------------------------------------------------
module val2_generator
  import exe_stage_unit_pkg::*;
(
  input  logic                    mem_op,
  input  logic                    immediate,
  input  logic [REGISTER_LEN-1:0] val_rm,
  input  logic [SHIFT_OP_LEN-1:0] shift_operand,
  output logic [REGISTER_LEN-1:0] val2
);

  logic [SHAMT_LEN-1:0] shift_imm;
  logic [SHAMT_LEN-1:0] rot_amt;
  shift_type_e          shift_type;

  assign shift_imm  = shift_operand[11:7];
  assign rot_amt    = {shift_operand[11:8], 1'b0};
  assign shift_type = shift_type_e'(shift_operand[6:5]);

  always_comb begin
    val2 = val_rm;
    if (mem_op) begin
      val2 = {{(REGISTER_LEN-SHIFT_OP_LEN){1'b0}}, shift_operand};
    end else if (immediate) begin
      val2 = ror_word({{(REGISTER_LEN-8){1'b0}}, shift_operand[7:0]}, rot_amt);
    end else if (shift_imm != '0) begin
      // A zero shift amount passes Rm through untouched for every type.
      unique case (shift_type)
        SHIFT_LSL: val2 = val_rm << shift_imm;
        SHIFT_LSR: val2 = val_rm >> shift_imm;
        SHIFT_ASR: val2 = $signed(val_rm) >>> shift_imm;
        SHIFT_ROR: val2 = ror_word(val_rm, shift_imm);
        default:   val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// ---------------------------------------------------------------------------
// exe_stage_unit
//   Execute stage: builds Val2, runs the ALU, computes the branch target,
//   owns the NZCV status register and registers results into EX->MEM.
//   Ports:
//     clk, rst (async, active-low), freeze (hold status + EX->MEM regs)
//     pc_in, control bits, execute_command_in, val_rn_in, val_rm_in,
//     immediate_in, signed_immediate_in, shift_operand_in, dest_reg_in
//     branch_taken_out, branch_address   combinational branch path
//     status_out                         registered {N,Z,C,V}
//     alu_result_out, val_rm_out, dest_reg_out,
//     mem_read_out, mem_write_out, wb_enable_out   EX->MEM registers
// ---------------------------------------------------------------------------
module exe_stage_unit
  import exe_stage_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic [ADDRESS_LEN-1:0]  pc_in,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic                    wb_enable_in,
  input  logic                    branch_taken_in,
  input  logic                    status_write_enable_in,
  input  logic [EXEC_CMD_LEN-1:0] execute_command_in,
  input  logic [REGISTER_LEN-1:0] val_rn_in,
  input  logic [REGISTER_LEN-1:0] val_rm_in,
  input  logic                    immediate_in,
  input  logic [23:0]             signed_immediate_in,
  input  logic [SHIFT_OP_LEN-1:0] shift_operand_in,
  input  logic [3:0]              dest_reg_in,
  output logic                    branch_taken_out,
  output logic [ADDRESS_LEN-1:0]  branch_address,
  output logic [3:0]              status_out,
  output logic [REGISTER_LEN-1:0] alu_result_out,
  output logic [REGISTER_LEN-1:0] val_rm_out,
  output logic [3:0]              dest_reg_out,
  output logic                    mem_read_out,
  output logic                    mem_write_out,
  output logic                    wb_enable_out
);

  localparam int W = REGISTER_LEN;

  logic                    mem_op;
  logic [W-1:0]            val2;
  exec_cmd_e               alu_cmd;
  logic                    carry_in;
  logic [W:0]              wide;
  logic [W-1:0]            alu_res;
  logic                    flag_c;
  logic                    flag_v;
  logic                    cmd_known;
  nzcv_t                   alu_flags;

  nzcv_t                   status_q,      status_d;
  logic [W-1:0]            alu_result_q,  alu_result_d;
  logic [W-1:0]            val_rm_q,      val_rm_d;
  logic [3:0]              dest_reg_q,    dest_reg_d;
  logic                    mem_read_q,    mem_read_d;
  logic                    mem_write_q,   mem_write_d;
  logic                    wb_enable_q,   wb_enable_d;

  assign mem_op = mem_read_in | mem_write_in;

  val2_generator u_val2 (
    .mem_op        (mem_op),
    .immediate     (immediate_in),
    .val_rm        (val_rm_in),
    .shift_operand (shift_operand_in),
    .val2          (val2)
  );

  // Loads/stores always compute the effective address with ADD.
  assign alu_cmd  = mem_op ? EXE_ADD : exec_cmd_e'(execute_command_in);
  assign carry_in = status_q.c;

  always_comb begin
    wide      = '0;
    alu_res   = '0;
    flag_c    = 1'b0;
    flag_v    = 1'b0;
    cmd_known = 1'b1;
    case (alu_cmd)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_ADD, EXE_ADC: begin
        wide = {1'b0, val_rn_in} + {1'b0, val2}
             + {{W{1'b0}}, (alu_cmd == EXE_ADC) & carry_in};
        alu_res = wide[W-1:0];
        flag_c  = wide[W];
        // Overflow: same-sign operands produce a result of the other sign.
        flag_v  = (val_rn_in[W-1] == val2[W-1]) && (alu_res[W-1] != val_rn_in[W-1]);
      end
      EXE_SUB, EXE_SBC: begin
        wide = {1'b0, val_rn_in} - {1'b0, val2}
             - {{W{1'b0}}, (alu_cmd == EXE_SBC) & ~carry_in};
        alu_res = wide[W-1:0];
        // Bit W of the 33-bit difference is the borrow; C is its inverse.
        flag_c  = ~wide[W];
        flag_v  = (val_rn_in[W-1] != val2[W-1]) && (alu_res[W-1] != val_rn_in[W-1]);
      end
      EXE_AND: alu_res = val_rn_in & val2;
      EXE_ORR: alu_res = val_rn_in | val2;
      EXE_EOR: alu_res = val_rn_in ^ val2;
      default: cmd_known = 1'b0;
    endcase
    alu_flags = cmd_known ? nzcv_t'({alu_res[W-1], ~|alu_res, flag_c, flag_v})
                          : nzcv_t'(4'b0000);
  end

  always_comb begin
    status_d     = status_q;
    alu_result_d = alu_result_q;
    val_rm_d     = val_rm_q;
    dest_reg_d   = dest_reg_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    wb_enable_d  = wb_enable_q;
    if (!freeze) begin
      if (status_write_enable_in && !mem_op) begin
        status_d = alu_flags;
      end
      alu_result_d = alu_res;
      val_rm_d     = val_rm_in;
      dest_reg_d   = dest_reg_in;
      mem_read_d   = mem_read_in;
      mem_write_d  = mem_write_in;
      wb_enable_d  = wb_enable_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q     <= '0;
      alu_result_q <= '0;
      val_rm_q     <= '0;
      dest_reg_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      wb_enable_q  <= 1'b0;
    end else begin
      status_q     <= status_d;
      alu_result_q <= alu_result_d;
      val_rm_q     <= val_rm_d;
      dest_reg_q   <= dest_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      wb_enable_q  <= wb_enable_d;
    end
  end

  // Branch offset is in words: sign-extend and scale by 4; wraps silently.
  assign branch_address   = pc_in + {{(ADDRESS_LEN-26){signed_immediate_in[23]}},
                                     signed_immediate_in, 2'b00};
  assign branch_taken_out = branch_taken_in;

  assign status_out     = status_q;
  assign alu_result_out = alu_result_q;
  assign val_rm_out     = val_rm_q;
  assign dest_reg_out   = dest_reg_q;
  assign mem_read_out   = mem_read_q;
  assign mem_write_out  = mem_write_q;
  assign wb_enable_out  = wb_enable_q;

endmodule
